// File: rtl/reg_dump_engine.sv
// reg_dump_engine
//
// Debugger-side reader for the register file's debug read port. A single
// dump_req pulse makes the engine walk registers START_REG..END_REG. Each
// value is sampled through the combinational debug read port and streamed
// one word at a time over a valid/ready handshake.
//
// Optional build macro: REG_DUMP_CHECKSUM_EN
//   If this macro is defined, one extra word follows the END_REG word.
//   That word holds the XOR of all dumped values, out_index = 0 and
//   out_last = 1.
//
// Parameters:
//   START_REG      first register index dumped (0..31)
//   END_REG        last register index dumped (START_REG..31)
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   dump_req       start pulse, honoured only while idle
//   dump_busy      high whenever the engine is not idle
//   dump_done      one-cycle pulse after the final word is accepted
//   dbg_read_addr  debug read address to the register file
//   dbg_read_val   combinational debug read data
//   out_valid      out_data/out_index/out_last are valid
//   out_ready      consumer accepts the word on valid && ready
//   out_data       registered register value
//   out_index      register index of out_data
//   out_last       marks the final word of the dump
module reg_dump_engine #(
    parameter int unsigned START_REG = 0,
    parameter int unsigned END_REG   = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dump_req,
    output logic        dump_busy,
    output logic        dump_done,
    output logic [4:0]  dbg_read_addr,
    input  logic [31:0] dbg_read_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_index,
    output logic        out_last
);

    localparam logic [4:0] START_IDX = START_REG[4:0];
    localparam logic [4:0] END_IDX   = END_REG[4:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_reg;
    logic [4:0]  counter_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        valid_reg;
    logic [31:0] data_reg;
    logic [4:0]  index_reg;
    logic        last_reg;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [31:0] checksum_reg;
`endif

    assign dbg_read_addr = counter_reg;
    assign dump_busy     = busy_reg;
    assign dump_done     = done_reg;
    assign out_valid     = valid_reg;
    assign out_data      = data_reg;
    assign out_index     = index_reg;
    assign out_last      = last_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            counter_reg  <= 5'd0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            valid_reg    <= 1'b0;
            data_reg     <= 32'd0;
            index_reg    <= 5'd0;
            last_reg     <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            checksum_reg <= 32'd0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (dump_req) begin
                        state_reg    <= READ;
                        counter_reg  <= START_IDX;
                        busy_reg     <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                        checksum_reg <= 32'd0;
`endif
                    end
                end

                READ: begin
                    data_reg     <= dbg_read_val;
                    index_reg    <= counter_reg;
                    valid_reg    <= 1'b1;
                    state_reg    <= SEND;
`ifdef REG_DUMP_CHECKSUM_EN
                    // The checksum word carries the last flag instead.
                    last_reg     <= 1'b0;
                    checksum_reg <= checksum_reg ^ dbg_read_val;
`else
                    last_reg     <= (counter_reg == END_IDX);
`endif
                end

                SEND: begin
                    if (valid_reg && out_ready) begin
                        if (last_reg) begin
                            valid_reg <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
`ifdef REG_DUMP_CHECKSUM_EN
                        end else if (counter_reg == END_IDX) begin
                            // END_REG word accepted: present the checksum
                            // word directly. No read cycle is needed.
                            // The accumulator already includes END_REG.
                            data_reg  <= checksum_reg;
                            index_reg <= 5'd0;
                            last_reg  <= 1'b1;
`endif
                        end else begin
                            counter_reg <= counter_reg + 5'd1;
                            valid_reg   <= 1'b0;
                            state_reg   <= READ;
                        end
                    end
                end

                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_engine.sv
// Testbench for reg_dump_engine.
//
// Three instances are used: the default range (0..31), the range 29..31,
// and the range 1..2. A register-file array feeds each debug read port.
// The stimulus pushes expected words into a scoreboard queue. A negedge
// monitor pops and compares each accepted word. The same monitor checks
// hold stability under backpressure and the dump_done pulse timing.
module tb_reg_dump_engine;

`ifdef REG_DUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req   [3];
    logic        rdy   [3];
    logic        busy  [3];
    logic        done  [3];
    logic        valid [3];
    logic        last  [3];
    logic [4:0]  addr  [3];
    logic [4:0]  idx   [3];
    logic [31:0] rval  [3];
    logic [31:0] data  [3];
    logic [31:0] regs  [32];

    assign rval[0] = regs[addr[0]];
    assign rval[1] = regs[addr[1]];
    assign rval[2] = regs[addr[2]];

    reg_dump_engine u0 (
        .clk(clk), .rst(rst), .dump_req(req[0]), .dump_busy(busy[0]),
        .dump_done(done[0]), .dbg_read_addr(addr[0]), .dbg_read_val(rval[0]),
        .out_valid(valid[0]), .out_ready(rdy[0]), .out_data(data[0]),
        .out_index(idx[0]), .out_last(last[0])
    );

    reg_dump_engine #(.START_REG(29), .END_REG(31)) u1 (
        .clk(clk), .rst(rst), .dump_req(req[1]), .dump_busy(busy[1]),
        .dump_done(done[1]), .dbg_read_addr(addr[1]), .dbg_read_val(rval[1]),
        .out_valid(valid[1]), .out_ready(rdy[1]), .out_data(data[1]),
        .out_index(idx[1]), .out_last(last[1])
    );

    reg_dump_engine #(.START_REG(1), .END_REG(2)) u2 (
        .clk(clk), .rst(rst), .dump_req(req[2]), .dump_busy(busy[2]),
        .dump_done(done[2]), .dbg_read_addr(addr[2]), .dbg_read_val(rval[2]),
        .out_valid(valid[2]), .out_ready(rdy[2]), .out_data(data[2]),
        .out_index(idx[2]), .out_last(last[2])
    );

    typedef struct {
        int          inst;
        logic [31:0] d;
        logic [4:0]  ix;
        logic        l;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor state
    logic        held [3];
    logic        due  [3];
    logic [31:0] sd   [3];
    logic [4:0]  si   [3];
    logic        sl   [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            held[i] = 1'b0;
            due[i]  = 1'b0;
            sd[i]   = 32'd0;
            si[i]   = 5'd0;
            sl[i]   = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                held[i] = 1'b0;
                due[i]  = 1'b0;
            end else begin
                chk($sformatf("done_pulse[%0d]", i), 32'(done[i]), 32'(due[i]));
                due[i] = 1'b0;
                if (held[i]) begin
                    chk($sformatf("hold_valid[%0d]", i), 32'(valid[i]), 32'd1);
                    chk($sformatf("hold_data[%0d]", i), data[i], sd[i]);
                    chk($sformatf("hold_index[%0d]", i), 32'(idx[i]), 32'(si[i]));
                    chk($sformatf("hold_last[%0d]", i), 32'(last[i]), 32'(sl[i]));
                end
                if (valid[i] && !rdy[i]) begin
                    held[i] = 1'b1;
                    sd[i]   = data[i];
                    si[i]   = idx[i];
                    sl[i]   = last[i];
                end else begin
                    held[i] = 1'b0;
                end
                if (valid[i] && rdy[i]) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word[%0d]: got index %0d data %h expected none",
                                 i, idx[i], data[i]);
                    end else begin
                        mon_e = q.pop_front();
                        chk($sformatf("word_inst[%0d]", i), 32'(i), 32'(mon_e.inst));
                        chk($sformatf("word_data[%0d] idx %0d", i, mon_e.ix), data[i], mon_e.d);
                        chk($sformatf("word_index[%0d]", i), 32'(idx[i]), 32'(mon_e.ix));
                        chk($sformatf("word_last[%0d] idx %0d", i, mon_e.ix),
                            32'(last[i]), 32'(mon_e.l));
                        due[i] = last[i];
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dump(input int inst, input int s, input int e);
        logic [31:0] acc;
        exp_t w;
        acc = 32'd0;
        for (int i = s; i <= e; i++) begin
            w.inst = inst;
            w.d    = regs[i];
            w.ix   = 5'(i);
            w.l    = (i == e) && (CS == 0);
            acc    = acc ^ regs[i];
            q.push_back(w);
        end
        if (CS != 0) begin
            w.inst = inst;
            w.d    = acc;
            w.ix   = 5'd0;
            w.l    = 1'b1;
            q.push_back(w);
        end
    endtask

    task automatic run_dump(input int inst, input int s, input int e,
                            input int stall_idx, input int stall_len, input bit pulse);
        int n;
        int stalled;
        bit pulsed;
        bit seen;
        int nw;
        nw = e - s + 1;
        push_dump(inst, s, e);
        rdy[inst] = 1'b1;
        req[inst] = 1'b1;
        step();
        req[inst] = 1'b0;
        chk($sformatf("busy_after_req[%0d]", inst), 32'(busy[inst]), 32'd1);
        n = 0;
        stalled = 0;
        pulsed = 1'b0;
        seen = 1'b0;
        while (n < 500 && !seen) begin
            step();
            n++;
            req[inst] = 1'b0;
            if (done[inst]) begin
                seen = 1'b1;
            end else begin
                if (valid[inst] && 32'(idx[inst]) == stall_idx && stalled < stall_len) begin
                    rdy[inst] = 1'b0;
                    stalled++;
                end else begin
                    rdy[inst] = 1'b1;
                end
                if (pulse && valid[inst] && !pulsed) begin
                    req[inst] = 1'b1;
                    pulsed = 1'b1;
                end
            end
        end
        rdy[inst] = 1'b1;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL dump_timeout[%0d]: got no dump_done within %0d cycles, required done",
                     inst, n);
            q.delete();
        end else begin
            chk($sformatf("done_latency[%0d]", inst), 32'(n), 32'(2 * nw + CS + stall_len));
            if (pulse) begin
                // dump_req is raised during DONE and must be dropped.
                req[inst] = 1'b1;
                step();
                req[inst] = 1'b0;
                chk($sformatf("req_in_done_ignored[%0d]", inst), 32'(busy[inst]), 32'd0);
                repeat (3) step();
                chk($sformatf("still_idle_busy[%0d]", inst), 32'(busy[inst]), 32'd0);
                chk($sformatf("still_idle_valid[%0d]", inst), 32'(valid[inst]), 32'd0);
            end else begin
                step();
                chk($sformatf("busy_after_done[%0d]", inst), 32'(busy[inst]), 32'd0);
            end
        end
        chk($sformatf("queue_drained[%0d]", inst), 32'(q.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input int i, input string tag);
        chk($sformatf("%s_valid[%0d]", tag, i), 32'(valid[i]), 32'd0);
        chk($sformatf("%s_data[%0d]", tag, i), data[i], 32'd0);
        chk($sformatf("%s_index[%0d]", tag, i), 32'(idx[i]), 32'd0);
        chk($sformatf("%s_last[%0d]", tag, i), 32'(last[i]), 32'd0);
        chk($sformatf("%s_busy[%0d]", tag, i), 32'(busy[i]), 32'd0);
        chk($sformatf("%s_done[%0d]", tag, i), 32'(done[i]), 32'd0);
        chk($sformatf("%s_addr[%0d]", tag, i), 32'(addr[i]), 32'd0);
    endtask

    initial begin
        int n;
        exp_t w;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0;
            rdy[i] = 1'b1;
        end
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i);
        regs[0] = 32'd0;

        // Reset state
        repeat (3) step();
        for (int i = 0; i < 3; i++) check_idle_outputs(i, "reset");
        rst = 1'b0;
        step();
        for (int i = 0; i < 3; i++) check_idle_outputs(i, "post_reset");

        // Reset during SEND at index 5
        for (int i = 0; i <= 4; i++) begin
            w.inst = 0;
            w.d    = regs[i];
            w.ix   = 5'(i);
            w.l    = 1'b0;
            q.push_back(w);
        end
        rdy[0] = 1'b1;
        req[0] = 1'b1;
        step();
        req[0] = 1'b0;
        n = 0;
        while (!(valid[0] && idx[0] == 5'd5) && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (!(valid[0] && idx[0] == 5'd5)) begin
            errors++;
            $display("FAIL reach_index5: got index %0d valid %0d, required index 5 valid 1",
                     idx[0], valid[0]);
        end
        rdy[0] = 1'b0;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check_idle_outputs(0, "async_reset");
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        rdy[0] = 1'b1;
        chk("reset_queue_drained", 32'(q.size()), 32'd0);
        q.delete();
        step();
        chk("no_done_after_reset", 32'(done[0]), 32'd0);
        chk("idle_after_reset", 32'(busy[0]), 32'd0);

        // Full default dump. It restarts at START_REG with ready held high.
        run_dump(0, 0, 31, -1, 0, 1'b0);

        // Backpressure: 7 stall cycles on index 3
        run_dump(0, 0, 31, 3, 7, 1'b0);

        // Range 29..31. Requests during SEND and DONE are ignored.
        run_dump(1, 29, 31, -1, 0, 1'b1);
        // A request from IDLE starts a second dump.
        run_dump(1, 29, 31, -1, 0, 1'b0);

        // Range 1..2 with specific values. A checksum word follows if enabled.
        regs[1] = 32'hA5A5_A5A5;
        regs[2] = 32'h0F0F_0F0F;
        run_dump(2, 1, 2, -1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
